// File: rtl/shift_engine.sv
// Multi-step shift/rotate engine: loads a register, then applies one single-bit
// shift or rotate per clock for a latched count, with a start/busy/done handshake.
module shift_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ip,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] op,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  typedef enum logic [2:0] {
    ModeSll  = 3'b000,
    ModeSrl  = 3'b001,
    ModeRol  = 3'b010,
    ModeRor  = 3'b011,
    ModeSra  = 3'b100,
    ModeSil  = 3'b101,
    ModeSir  = 3'b110,
    ModeHold = 3'b111
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_op;
  logic             step_sout;

  // Result of a single step in the latched mode.
  always_comb begin
    step_op   = op_q;
    step_sout = op_q[WIDTH-1];
    unique case (mode_q)
      ModeSll: step_op = {op_q[WIDTH-2:0], 1'b0};
      ModeSrl: begin
        step_op   = {1'b0, op_q[WIDTH-1:1]};
        step_sout = op_q[0];
      end
      ModeRol: step_op = {op_q[WIDTH-2:0], op_q[WIDTH-1]};
      ModeRor: begin
        step_op   = {op_q[0], op_q[WIDTH-1:1]};
        step_sout = op_q[0];
      end
      ModeSra: begin
        step_op   = {op_q[WIDTH-1], op_q[WIDTH-1:1]};
        step_sout = op_q[0];
      end
      ModeSil: step_op = {op_q[WIDTH-2:0], sin};
      ModeSir: begin
        step_op   = {sin, op_q[WIDTH-1:1]};
        step_sout = op_q[0];
      end
      ModeHold: step_op = op_q;
      default: step_op = op_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          op_d = ip;
        end else if (start) begin
          if (amt != '0) begin
            mode_d  = mode_e'(mode);
            cnt_d   = amt;
            state_d = StShift;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StShift: begin
        op_d   = step_op;
        sout_d = step_sout;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      mode_q  <= ModeSll;
      cnt_q   <= '0;
      op_q    <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign op   = op_q;
  assign sout = sout_q;
  assign busy = (state_q == StShift);
  assign done = done_q;

endmodule
